// File: rtl/wb_regfile_pkg.sv
// Shared constants and helpers for the write-back stage and register file.
// Imported by the interface, the storage array and the top.
package wb_regfile_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 32;

  localparam logic [3:0] TRACE_WEN_ALL = 4'hF;
  localparam logic [3:0] TRACE_WEN_NONE = 4'h0;

  // One-entry WB slot occupancy
  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  function automatic logic [3:0] trace_wen(input logic commit);
    return commit ? TRACE_WEN_ALL : TRACE_WEN_NONE;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// EX -> WB handshake bundle: ALU result, write enable, destination and PC,
// with the ready signal returned by the WB stage.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();

  logic              valid;
  logic              ready;
  logic              en_reg_write;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_value;
  logic [PC_W-1:0]   pc;

  modport master (
    output valid,
    output en_reg_write,
    output rd_addr,
    output rd_value,
    output pc,
    input  ready
  );

  modport slave (
    input  valid,
    input  en_reg_write,
    input  rd_addr,
    input  rd_value,
    input  pc,
    output ready
  );

endinterface

// File: rtl/wb_regfile_rf_array.sv
// General register storage: one synchronous write port, two asynchronous read
// ports; register 0 is never written and always reads as zero.
module wb_regfile_rf_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:NREGS-1];

  generate
    if (CLEAR_ON_RESET) begin : g_clear
      always_ff @(posedge clk) begin
        if (!resetn) begin
          for (int i = 0; i < NREGS; i++) begin
            mem[i] <= '0;
          end
        end else if (we && (waddr != '0)) begin
          mem[waddr] <= wdata;
        end
      end
    end else begin : g_keep
      // Contents survive reset; only writes are suppressed while it is held.
      always_ff @(posedge clk) begin
        if (resetn && we && (waddr != '0)) begin
          mem[waddr] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: captures the EX result into a one-entry WB slot, commits it
// to the register file, bypasses it to both read ports, and drives the trace.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              freeze,
  wb_regfile_if.slave       ex,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata,
  output logic [CNT_W-1:0]  retire_cnt
);

  logic [0:0]        slot_p1;
  logic              vld_p1;
  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;
  logic [PC_W-1:0]   pc_p1;
  logic [CNT_W-1:0]  cnt_p1;

  logic              accept;
  logic              commit;
  logic              byp1;
  logic              byp2;
  logic [DATA_W-1:0] arr_rdata1;
  logic [DATA_W-1:0] arr_rdata2;

  assign ex.ready = ~freeze;
  assign accept   = ex.valid & ~freeze;
  assign vld_p1   = (slot_p1 == SLOT_FULL);
  assign commit   = vld_p1 & we_p1 & ~freeze;

  // ---- EX -> WB (p1) boundary ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_p1 <= SLOT_EMPTY;
      we_p1   <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      pc_p1   <= '0;
      cnt_p1  <= '0;
    end else if (!freeze) begin
      slot_p1 <= accept ? SLOT_FULL : SLOT_EMPTY;
      if (accept) begin
        we_p1   <= ex.en_reg_write;
        addr_p1 <= ex.rd_addr;
        data_p1 <= ex.rd_value;
        pc_p1   <= ex.pc;
      end
      if (vld_p1) begin
        cnt_p1 <= cnt_p1 + CNT_W'(1);
      end
    end
  end

  // ---- WB (p1) -> architectural state boundary ----
  wb_regfile_rf_array #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_rf_array (
    .clk    (clk),
    .resetn (resetn),
    .we     (commit),
    .waddr  (addr_p1),
    .wdata  (data_p1),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (arr_rdata1),
    .rdata2 (arr_rdata2)
  );

  // The pending WB value is forwarded even while frozen; reg 0 is never forwarded.
  assign byp1 = resetn & vld_p1 & we_p1 & (raddr1 != '0) & (addr_p1 == raddr1);
  assign byp2 = resetn & vld_p1 & we_p1 & (raddr2 != '0) & (addr_p1 == raddr2);

  assign rdata1 = byp1 ? data_p1 : arr_rdata1;
  assign rdata2 = byp2 ? data_p1 : arr_rdata2;

  assign debug_wb_rf_wen   = resetn ? trace_wen(commit) : TRACE_WEN_NONE;
  assign debug_wb_rf_wnum  = resetn ? addr_p1 : '0;
  assign debug_wb_rf_wdata = resetn ? data_p1 : '0;
  assign debug_wb_pc       = resetn ? pc_p1   : '0;
  assign retire_cnt        = resetn ? cnt_p1  : '0;

endmodule
